gx4000_dma_sequencer: RTL and testbench

Parametrised Plus/GX4000 ASIC sound-DMA sequencer with NUM_CH independent channels. Once per scanline, each channel fetches one 16-bit instruction from memory and executes it. Instructions can write PSG registers, pause the channel, run repeat loops, raise interrupts or stop the channel. The block sits between the CPU register decode, the shared memory arbiter and the PSG write port inside the GX4000 subsystem, and generalises the fixed 3-channel ASIC DMA.

---
 rtl/gx4000_dma_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_gx4000_dma_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx4000_dma_sequencer.sv
// Multi-channel Plus/GX4000 sound-DMA sequencer: each enabled channel fetches and
// executes one 16-bit instruction per scanline through a shared IDLE/FETCH/EXEC engine.
module gx4000_dma_sequencer #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 16,
    parameter int PAUSE_W = 12
) (
    input  logic                                          clk_sys,
    input  logic                                          reset,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic                                          ch_addr_wr,
    input  logic [ADDR_W-1:0]                             ch_addr_din,
    input  logic                                          ch_presc_wr,
    input  logic [7:0]                                    ch_presc_din,
    input  logic [NUM_CH-1:0]                             ch_enable,
    input  logic                                          line_strobe,
    output logic                                          mem_req,
    output logic [ADDR_W-1:0]                             mem_addr,
    input  logic                                          mem_ack,
    input  logic [15:0]                                   mem_data,
    output logic                                          psg_wr,
    output logic [3:0]                                    psg_reg,
    output logic [7:0]                                    psg_data,
    output logic [NUM_CH-1:0]                             irq,
    input  logic [NUM_CH-1:0]                             irq_clr,
    output logic                                          busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_t;

    logic [ADDR_W-1:0]  ptr_q       [NUM_CH];
    logic [ADDR_W-1:0]  ptr_d       [NUM_CH];
    logic [ADDR_W-1:0]  loop_addr_q [NUM_CH];
    logic [ADDR_W-1:0]  loop_addr_d [NUM_CH];
    logic [PAUSE_W-1:0] pause_cnt_q [NUM_CH];
    logic [PAUSE_W-1:0] pause_cnt_d [NUM_CH];
    logic [PAUSE_W-1:0] loop_cnt_q  [NUM_CH];
    logic [PAUSE_W-1:0] loop_cnt_d  [NUM_CH];
    logic [7:0]         presc_q     [NUM_CH];
    logic [7:0]         presc_d     [NUM_CH];
    logic [7:0]         presc_cnt_q [NUM_CH];
    logic [7:0]         presc_cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  active_q, active_d;
    logic [NUM_CH-1:0]  pending_q, pending_d;
    logic [NUM_CH-1:0]  irq_q, irq_d;

    state_t             state_q;
    logic [CH_W-1:0]    cur_q;
    logic [15:0]        op_q;
    logic               discard_q;
    logic               mem_req_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic               psg_wr_q;
    logic [3:0]         psg_reg_q;
    logic [7:0]         psg_data_q;
    logic               busy_q;

    logic               sel_ok;
    logic               cur_wr;
    logic               exec_en;
    logic [3:0]         opc;
    logic [PAUSE_W-1:0] op_n;
    logic [NUM_CH-1:0]  pend_mask;
    logic [NUM_CH-1:0]  next_mask;
    logic [CH_W-1:0]    first_ch;
    logic [CH_W-1:0]    next_ch;

    function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // A pointer write to the channel being serviced kills its instruction,
    // whether it lands during the fetch (discard_q) or in the EXEC cycle itself.
    assign sel_ok  = (int'(ch_sel) < NUM_CH);
    assign cur_wr  = ch_addr_wr && (ch_sel == cur_q);
    assign exec_en = (state_q == S_EXEC) && !discard_q && !cur_wr;
    assign opc     = op_q[15:12];
    assign op_n    = op_q[PAUSE_W-1:0];

    always_comb begin
        pend_mask = pending_q & ch_enable;
        for (int c = 0; c < NUM_CH; c++) begin
            next_mask[c] = pend_mask[c] && (CH_W'(c) != cur_q);
        end
        first_ch = lowest(pend_mask);
        next_ch  = lowest(next_mask);
    end

    always_comb begin
        ptr_d       = ptr_q;
        loop_addr_d = loop_addr_q;
        pause_cnt_d = pause_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        active_d    = active_q;
        pending_d   = pending_q;
        irq_d       = irq_q & ~irq_clr;

        // Scanline tick: paused channels count down, runnable ones queue a fetch.
        for (int c = 0; c < NUM_CH; c++) begin
            if (line_strobe && ch_enable[c]) begin
                if (pause_cnt_q[c] != '0) begin
                    if (presc_cnt_q[c] == 8'd0) begin
                        presc_cnt_d[c] = presc_q[c];
                        pause_cnt_d[c] = pause_cnt_q[c] - PAUSE_W'(1);
                    end else begin
                        presc_cnt_d[c] = presc_cnt_q[c] - 8'd1;
                    end
                end else if (active_q[c]) begin
                    pending_d[c] = 1'b1;
                end
            end
        end

        if (exec_en) begin
            pending_d[cur_q] = 1'b0;
            ptr_d[cur_q]     = ptr_q[cur_q] + ADDR_W'(2);
            case (opc)
                4'h1: begin
                    if (op_n != '0) begin
                        pause_cnt_d[cur_q] = op_n;
                        presc_cnt_d[cur_q] = presc_q[cur_q];
                    end
                end
                4'h2: begin
                    loop_cnt_d[cur_q]  = op_n;
                    loop_addr_d[cur_q] = ptr_q[cur_q] + ADDR_W'(2);
                end
                4'h4: begin
                    if (op_q[4]) irq_d[cur_q] = 1'b1;
                    if (op_q[0]) begin
                        if (loop_cnt_q[cur_q] > PAUSE_W'(1)) begin
                            loop_cnt_d[cur_q] = loop_cnt_q[cur_q] - PAUSE_W'(1);
                            ptr_d[cur_q]      = loop_addr_q[cur_q];
                        end else begin
                            loop_cnt_d[cur_q] = '0;
                        end
                    end
                    if (op_q[5]) active_d[cur_q] = 1'b0;
                end
                default: ;
            endcase
        end

        // CPU configuration writes take priority over the sequencer.
        if (ch_addr_wr && sel_ok) begin
            ptr_d[ch_sel]       = {ch_addr_din[ADDR_W-1:1], 1'b0};
            active_d[ch_sel]    = 1'b1;
            pause_cnt_d[ch_sel] = '0;
            loop_cnt_d[ch_sel]  = '0;
            pending_d[ch_sel]   = 1'b0;
        end
        if (ch_presc_wr && sel_ok) begin
            presc_d[ch_sel] = ch_presc_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c]       <= '0;
                loop_addr_q[c] <= '0;
                pause_cnt_q[c] <= '0;
                loop_cnt_q[c]  <= '0;
                presc_q[c]     <= '0;
                presc_cnt_q[c] <= '0;
            end
            active_q  <= '0;
            pending_q <= '0;
            irq_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            loop_addr_q <= loop_addr_d;
            pause_cnt_q <= pause_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            op_q       <= '0;
            discard_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            psg_wr_q   <= 1'b0;
            psg_reg_q  <= '0;
            psg_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            psg_wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|pend_mask) begin
                        state_q    <= S_FETCH;
                        cur_q      <= first_ch;
                        mem_addr_q <= ptr_q[first_ch];
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        discard_q  <= ch_addr_wr && (ch_sel == first_ch);
                    end
                end
                S_FETCH: begin
                    if (cur_wr) discard_q <= 1'b1;
                    if (mem_ack) begin
                        op_q      <= mem_data;
                        mem_req_q <= 1'b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_en && (opc == 4'h0)) begin
                        psg_wr_q   <= 1'b1;
                        psg_reg_q  <= op_q[11:8];
                        psg_data_q <= op_q[7:0];
                    end
                    if (|next_mask) begin
                        state_q    <= S_FETCH;
                        cur_q      <= next_ch;
                        mem_addr_q <= ptr_q[next_ch];
                        mem_req_q  <= 1'b1;
                        discard_q  <= ch_addr_wr && (ch_sel == next_ch);
                    end else begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        discard_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign psg_wr   = psg_wr_q;
    assign psg_reg  = psg_reg_q;
    assign psg_data = psg_data_q;
    assign irq      = irq_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_gx4000_dma_sequencer.sv
// Scoreboard bench for gx4000_dma_sequencer: directed instruction streams, a memory
// responder with configurable ack latency, and a monitor checking fetch/PSG events in order.
module tb_gx4000_dma_sequencer;

    localparam int NUM_CH = 3;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ch_sel = '0;
    logic        ch_addr_wr = 1'b0;
    logic [15:0] ch_addr_din = '0;
    logic        ch_presc_wr = 1'b0;
    logic [7:0]  ch_presc_din = '0;
    logic [2:0]  ch_enable = '0;
    logic        line_strobe = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;
    logic        psg_wr;
    logic [3:0]  psg_reg;
    logic [7:0]  psg_data;
    logic [2:0]  irq;
    logic [2:0]  irq_clr = '0;
    logic        busy;

    gx4000_dma_sequencer #(.NUM_CH(NUM_CH), .ADDR_W(16), .PAUSE_W(12)) dut (
        .clk_sys(clk_sys), .reset(reset), .ch_sel(ch_sel),
        .ch_addr_wr(ch_addr_wr), .ch_addr_din(ch_addr_din),
        .ch_presc_wr(ch_presc_wr), .ch_presc_din(ch_presc_din),
        .ch_enable(ch_enable), .line_strobe(line_strobe),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .psg_wr(psg_wr), .psg_reg(psg_reg), .psg_data(psg_data),
        .irq(irq), .irq_clr(irq_clr), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic        is_psg;
        logic [15:0] val;
    } evt_t;

    evt_t        exp_q[$];
    logic [15:0] mem [int];
    int          ack_delay = 0;
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'h3000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic push_fetch(input logic [15:0] a);
        exp_q.push_back('{is_psg: 1'b0, val: a});
    endtask

    task automatic push_psg(input logic [3:0] r, input logic [7:0] d);
        exp_q.push_back('{is_psg: 1'b1, val: {4'h0, r, d}});
    endtask

    task automatic see(input logic is_psg, input logic [15:0] v);
        evt_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected %s event: got 0x%0h required none", is_psg ? "psg" : "fetch", v);
        end else begin
            e = exp_q.pop_front();
            if (e.is_psg == is_psg && e.val == v) n_pass++;
            else $display("FAIL event order: got %s 0x%0h required %s 0x%0h",
                          is_psg ? "psg" : "fetch", v, e.is_psg ? "psg" : "fetch", e.val);
        end
    endtask

    // Monitor: PSG write belongs to the earlier instruction, so it is scored first.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (psg_wr) see(1'b1, {4'h0, psg_reg, psg_data});
            if (mem_req && !prev_req) see(1'b0, mem_addr);
            prev_req = mem_req;
        end
    end

    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk_sys);
            if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = rd(mem_addr);
                    wait_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic set_ptr(input int ch, input logic [15:0] a);
        @(negedge clk_sys);
        ch_sel = 2'(ch); ch_addr_din = a; ch_addr_wr = 1'b1;
        @(negedge clk_sys);
        ch_addr_wr = 1'b0;
    endtask

    task automatic set_presc(input int ch, input logic [7:0] p);
        @(negedge clk_sys);
        ch_sel = 2'(ch); ch_presc_din = p; ch_presc_wr = 1'b1;
        @(negedge clk_sys);
        ch_presc_wr = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk_sys);
        line_strobe = 1'b1;
        @(negedge clk_sys);
        line_strobe = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        repeat (4) @(negedge clk_sys);
        while ((exp_q.size() != 0 || busy) && cyc < 200) begin
            @(negedge clk_sys);
            cyc++;
        end
        repeat (3) @(negedge clk_sys);
        n_total++;
        if (exp_q.size() == 0 && !busy) n_pass++;
        else $display("FAIL drain %s: outstanding=%0d busy=%0b required 0/0", name, exp_q.size(), busy);
    endtask

    task automatic line(input string name);
        strobe();
        drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[16'h0100] = 16'h0712; mem[16'h0102] = 16'h4020;
        mem[16'h0200] = 16'h1003; mem[16'h0202] = 16'h0A33; mem[16'h0204] = 16'h4020;
        mem[16'h0300] = 16'h2002; mem[16'h0302] = 16'h0155; mem[16'h0304] = 16'h4001;
        mem[16'h0306] = 16'h4020;
        mem[16'h0400] = 16'h0111; mem[16'h0500] = 16'h0222; mem[16'h0600] = 16'h0333;
        mem[16'h0700] = 16'h4010; mem[16'h0702] = 16'h4010; mem[16'h0704] = 16'h4020;
        mem[16'h0800] = 16'h10FF; mem[16'h0900] = 16'h0C44; mem[16'h0902] = 16'h4020;
        mem[16'h0A00] = 16'h0D55; mem[16'h0B00] = 16'h0E66; mem[16'h0B02] = 16'h4020;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        chk("reset mem_req", 32'(mem_req), 32'h0);
        chk("reset psg_wr", 32'(psg_wr), 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);

        // Basic LOAD then STOP, with strobe-to-request latency.
        ch_enable = 3'b001;
        set_ptr(0, 16'h0100);
        push_fetch(16'h0100); push_psg(4'h7, 8'h12);
        strobe();
        chk("req at t+1", 32'(mem_req), 32'h0);
        @(negedge clk_sys);
        chk("req at t+2", 32'(mem_req), 32'h1);
        chk("addr at t+2", 32'(mem_addr), 32'h0100);
        drain("load");
        push_fetch(16'h0102);
        line("stop");
        line("stopped");

        // PAUSE 3 with prescaler 1: next fetch on the 7th strobe.
        ch_enable = 3'b010;
        set_presc(1, 8'd1);
        set_ptr(1, 16'h0200);
        push_fetch(16'h0200);
        line("pause");
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) begin
                push_fetch(16'h0202); push_psg(4'hA, 8'h33);
            end
            line("pause wait");
        end
        push_fetch(16'h0204);
        line("pause stop");

        // REPEAT 2 / LOAD / LOOP / STOP.
        ch_enable = 3'b100;
        set_ptr(2, 16'h0300);
        push_fetch(16'h0300);
        line("repeat");
        push_fetch(16'h0302); push_psg(4'h1, 8'h55);
        line("body1");
        push_fetch(16'h0304);
        line("loop1");
        push_fetch(16'h0302); push_psg(4'h1, 8'h55);
        line("body2");
        push_fetch(16'h0304);
        line("loop2");
        push_fetch(16'h0306);
        line("repeat stop");
        line("repeat stopped");

        // Three channels on one strobe with slow memory.
        ack_delay = 2;
        ch_enable = 3'b111;
        set_ptr(0, 16'h0400);
        set_ptr(1, 16'h0500);
        set_ptr(2, 16'h0600);
        push_fetch(16'h0400); push_psg(4'h1, 8'h11);
        push_fetch(16'h0500); push_psg(4'h2, 8'h22);
        push_fetch(16'h0600); push_psg(4'h3, 8'h33);
        line("three ch");
        chk("busy after three", 32'(busy), 32'h0);
        ack_delay = 0;

        // Sticky IRQ, then clear colliding with a new INT.
        ch_enable = 3'b001;
        set_ptr(0, 16'h0700);
        push_fetch(16'h0700);
        line("int1");
        chk("irq set", 32'(irq), 32'h1);
        repeat (5) @(negedge clk_sys);
        chk("irq held", 32'(irq), 32'h1);
        irq_clr = 3'b001;
        @(negedge clk_sys);
        irq_clr = 3'b000;
        chk("irq cleared", 32'(irq), 32'h0);
        push_fetch(16'h0702);
        strobe();
        @(negedge clk_sys);
        @(negedge clk_sys);
        irq_clr = 3'b001;
        @(negedge clk_sys);
        irq_clr = 3'b000;
        chk("irq set beats clr", 32'(irq), 32'h1);
        drain("int2");
        irq_clr = 3'b001;
        @(negedge clk_sys);
        irq_clr = 3'b000;
        chk("irq cleared again", 32'(irq), 32'h0);
        push_fetch(16'h0704);
        line("int stop");

        // Pointer write to a paused channel clears the pause.
        ch_enable = 3'b010;
        set_ptr(1, 16'h0800);
        push_fetch(16'h0800);
        line("long pause");
        line("paused1");
        line("paused2");
        set_ptr(1, 16'h0901);
        push_fetch(16'h0900); push_psg(4'hC, 8'h44);
        line("repoint");
        push_fetch(16'h0902);
        line("repoint stop");

        // Pointer write while the fetch is in flight discards the fetched word.
        ack_delay = 3;
        ch_enable = 3'b100;
        set_ptr(2, 16'h0A00);
        push_fetch(16'h0A00);
        strobe();
        @(negedge clk_sys);
        chk("inflight req", 32'(mem_req), 32'h1);
        set_ptr(2, 16'h0B00);
        chk("inflight addr stable", 32'(mem_addr), 32'h0A00);
        drain("discard");
        ack_delay = 0;
        push_fetch(16'h0B00); push_psg(4'hE, 8'h66);
        line("after discard");
        push_fetch(16'h0B02);
        line("discard stop");
        chk("final busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
